ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
- Single-initiator AHB-Lite master that turns a simple command/response interface into AHB-Lite single transfers (HBURST=SINGLE).
- It is the initiator for the AHB-Lite slaves on the bus. It drives HADDR/HTRANS/HWRITE/HSIZE/HWDATA and consumes HREADY/HRESP/HRDATA.
- Supports AHB address/data pipelining: the next address phase overlaps the current data phase.
- Handles the two-cycle ERROR response.

Parameters:
- ADDR_W, 32, width of HADDR and cmd_addr.
- DATA_W, 32, width of HWDATA/HRDATA/cmd_wdata/rsp_rdata.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle when cmd_valid=1.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_size  in  HSIZE_E  BYTE/HALF_WORD/WORD.
- cmd_wdata  in  DATA_W  write data, placed on HWDATA unmodified.
- rsp_valid  out  1  one-cycle pulse per completed transfer.
- rsp_rdata  out  DATA_W  HRDATA captured for reads; 0 for writes.
- rsp_error  out  1  transfer ended with HRESP=ERROR.
- HADDR  out  ADDR_W  address.
- HTRANS  out  HTRANS_E  IDLE or NONSEQ only.
- HWRITE  out  1  direction.
- HSIZE  out  HSIZE_E  transfer size.
- HBURST  out  3  constant SINGLE (3'b000).
- HPROT  out  4  constant 4'b0011.
- HWDATA  out  DATA_W  write data, data phase.
- HREADY  in  1  transfer-done / bus-ready from the slave mux.
- HRESP  in  1  0=OKAY, 1=ERROR.
- HRDATA  in  DATA_W  read data.

Behaviour:
- State elements:
  - Address-phase register A: valid, addr, write, size, wdata.
  - Data-phase register D: valid, write, wdata.
  - hold flag.
  - Response registers.
- All AHB outputs are registered, except HTRANS, which is decoded from A.valid and hold.
- Reset: any rising HCLK edge with HRESETn=0 clears A, D, hold, rsp_valid, rsp_rdata, rsp_error. After reset:
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=BYTE, HWDATA=0.
  - cmd_ready=0 while HRESETn=0.
  - Reset mid-transfer abandons it; no response is issued.
- Bus outputs: HTRANS=NONSEQ when A.valid && !hold, else IDLE. HADDR/HWRITE/HSIZE come from A.
- Alignment: HADDR low bits are forced to 0 per size (HALF_WORD clears bit0; WORD clears bits[1:0]).
- cmd_ready (combinational) = HRESETn && !hold && (!A.valid || HREADY).
- Edge with HREADY=1 and hold=0:
  - D <= A; D.valid=A.valid.
  - A <= command if cmd_valid && cmd_ready, else A.valid <= 0.
- Edge with HREADY=1 and hold=1: hold <= 0. A is retained and reissued as NONSEQ next cycle. D.valid <= 0.
- Edge with HREADY=0:
  - A and D hold. HWDATA stays stable.
  - If D.valid && HRESP=1 (first ERROR cycle), set hold <= 1. The pending address phase is cancelled to IDLE for the second ERROR cycle, not lost.
- Completion: an edge with D.valid && HREADY=1 completes the transfer. On the following cycle:
  - rsp_valid=1.
  - rsp_error=HRESP.
  - rsp_rdata=HRDATA if !D.write, else 0.
- Latency:
  - A command accepted at edge N is in address phase in cycle N+1.
  - With zero wait states, data phase is cycle N+2 and rsp_valid is asserted in cycle N+3.
  - Each wait state adds 1 cycle.
- Throughput: back-to-back commands give one transfer per cycle with no wait states.
- Simultaneous events: cmd_valid arriving on the same edge as the final ERROR cycle is refused (cmd_ready=0 because hold=1).
- Outstanding transfers: at most 2 (one in A, one in D); no reordering.

Decomposition:
- slave_package gains:
  - HTRANS_E (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11).
  - Constants HBURST_SINGLE=3'b000 and HPROT_DEFAULT=4'b0011.
  - HSIZE_E is reused as-is.
- No sub-module; the A/D pipeline and hold logic are small enough to live in one module.

Test Plan:
1. Reset held 3 cycles, release -> HTRANS=IDLE, rsp_valid=0, cmd_ready=1 on the first cycle after release.
2. Write WORD addr 32'h0000_0010 data 32'hDEADBEEF, HREADY=1 -> NONSEQ/HWRITE=1 one cycle, HWDATA=32'hDEADBEEF next cycle, rsp_valid with rsp_error=0 next.
3. Read HALF_WORD addr 32'h0000_0023, slave inserts 2 wait states and returns HRDATA=32'hFEDC_BA98 -> HADDR=32'h0000_0022, rsp_rdata=32'hFEDCBA98 exactly 2 cycles later than the zero-wait case.
4. Four back-to-back writes (addrs 0x0, 0x4, 0x8, 0xC) with HREADY=1 -> four consecutive NONSEQ cycles, four consecutive rsp_valid pulses in order.
5. Write 0x0 then read 0x4; slave answers ERROR (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) on the write -> HTRANS=IDLE in the second ERROR cycle, then read 0x4 reissued as NONSEQ; responses are (error=1) then (error=0).
6. HRESETn=0 asserted during a wait-stated read -> next cycle HTRANS=IDLE, no rsp_valid ever issued for that read.

Source files
------------

// File: rtl/ahb_lite_master_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_master_pkg
//   Shared AHB-Lite types and constants for the single-initiator master.
//   Contents:
//     hsize_e        - HSIZE encodings (BYTE / HALF_WORD / WORD)
//     htrans_e       - HTRANS encodings (IDLE / BUSY / NONSEQ / SEQ)
//     HBURST_SINGLE  - constant burst type driven on HBURST
//     HPROT_DEFAULT  - constant protection attributes driven on HPROT
//     align_low()    - clears the low address bits a given size cannot use
// ---------------------------------------------------------------------------
package ahb_lite_master_pkg;

  typedef enum logic [2:0] {
    BYTE      = 3'b000,
    HALF_WORD = 3'b001,
    WORD      = 3'b010
  } hsize_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Halfword transfers must be 2-byte aligned and word transfers 4-byte
  // aligned, so the offending low bits are simply dropped.
  function automatic logic [1:0] align_low(input logic [1:0] lo, input hsize_e size);
    logic [1:0] res;
    res = lo;
    case (size)
      HALF_WORD: res = {lo[1], 1'b0};
      WORD:      res = 2'b00;
      default:   res = lo;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
//   Turns a valid/ready command interface into AHB-Lite SINGLE transfers.
//   Address phase of the next transfer overlaps the data phase of the
//   current one (register A = address phase, register D = data phase), so at
//   most two transfers are in flight. A two-cycle ERROR response cancels the
//   pending address phase to IDLE for one cycle and then reissues it.
//
//   Ports:
//     HCLK, HRESETn             bus clock, synchronous active-low reset
//     cmd_valid/cmd_ready       command handshake
//     cmd_write/addr/size/wdata command contents
//     rsp_valid/rdata/error     one-cycle completion pulse and its result
//     HADDR/HTRANS/HWRITE/HSIZE address-phase outputs
//     HBURST/HPROT              constant SINGLE / 4'b0011
//     HWDATA                    data-phase write data
//     HREADY/HRESP/HRDATA       slave response inputs
// ---------------------------------------------------------------------------
module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  hsize_e            cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,

  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,

  output logic [ADDR_W-1:0] HADDR,
  output htrans_e           HTRANS,
  output logic              HWRITE,
  output hsize_e            HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA
);

  // Address-phase register
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic              a_write;
  hsize_e            a_size;
  logic [DATA_W-1:0] a_wdata;

  // Data-phase register
  logic              d_valid;
  logic              d_write;
  logic [DATA_W-1:0] d_wdata;

  // Set during the second ERROR cycle to park the pending address phase.
  logic              hold;

  // HTRANS is the only bus output decoded combinationally: it must drop to
  // IDLE in the same cycle hold rises, without losing A.
  always_comb begin
    HTRANS    = IDLE;
    cmd_ready = 1'b0;
    if (a_valid && !hold) HTRANS = NONSEQ;
    cmd_ready = HRESETn && !hold && (!a_valid || HREADY);
  end

  assign HADDR  = a_addr;
  assign HWRITE = a_write;
  assign HSIZE  = a_size;
  assign HWDATA = d_wdata;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_DEFAULT;

  // Pipeline advance, ERROR hold handling and response capture.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      a_valid   <= 1'b0;
      a_addr    <= '0;
      a_write   <= 1'b0;
      a_size    <= BYTE;
      a_wdata   <= '0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      d_wdata   <= '0;
      hold      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (d_valid && HREADY) begin
        rsp_valid <= 1'b1;
        rsp_error <= HRESP;
        rsp_rdata <= d_write ? '0 : HRDATA;
      end

      if (HREADY) begin
        if (hold) begin
          // Final ERROR cycle: D retires, A stays and is reissued next cycle.
          hold    <= 1'b0;
          d_valid <= 1'b0;
        end else begin
          d_valid <= a_valid;
          d_write <= a_write;
          d_wdata <= a_wdata;
          if (cmd_valid && cmd_ready) begin
            a_valid <= 1'b1;
            a_addr  <= {cmd_addr[ADDR_W-1:2], align_low(cmd_addr[1:0], cmd_size)};
            a_write <= cmd_write;
            a_size  <= cmd_size;
            a_wdata <= cmd_wdata;
          end else begin
            a_valid <= 1'b0;
          end
        end
      end else if (d_valid && HRESP) begin
        hold <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_master
//   Directed bench for ahb_lite_master. Inputs are driven #1 after each rising
//   edge and outputs are observed at that same point, i.e. they reflect the
//   cycle that the edge just started.
// ---------------------------------------------------------------------------
module tb_ahb_lite_master;
  import ahb_lite_master_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  hsize_e      cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] HADDR;
  htrans_e     HTRANS;
  logic        HWRITE;
  hsize_e      HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  int tests_run;
  int tests_failed;

  ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic offer(input logic wr, input logic [31:0] addr, input hsize_e size,
                       input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_cmd_ready cyc %0d: got %b want 0", i, cmd_ready);
      end
    end
    tests_run++;
    if (HTRANS !== IDLE || HADDR !== 32'h0 || HWDATA !== 32'h0 || HWRITE !== 1'b0 ||
        HSIZE !== BYTE || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: htrans=%0d haddr=%h hwdata=%h hwrite=%b hsize=%0d rsp_valid=%b want 0/0/0/0/0/0",
               HTRANS, HADDR, HWDATA, HWRITE, HSIZE, rsp_valid);
    end
    tests_run++;
    if (HBURST !== 3'b000 || HPROT !== 4'b0011) begin
      tests_failed++;
      $display("[TB] FAIL constants: hburst=%b hprot=%b want 000/0011", HBURST, HPROT);
    end
    HRESETn = 1'b1;
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1 || HTRANS !== IDLE || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset: cmd_ready=%b htrans=%0d rsp_valid=%b want 1/0/0",
               cmd_ready, HTRANS, rsp_valid);
    end
    tick();
  endtask

  task automatic test_write;
    offer(1'b1, 32'h0000_0010, WORD, 32'hDEADBEEF);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL write_ready: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    tests_run++;
    if (HTRANS !== NONSEQ || HWRITE !== 1'b1 || HADDR !== 32'h0000_0010 || HSIZE !== WORD ||
        rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_addr_phase: htrans=%0d hwrite=%b haddr=%h hsize=%0d rsp_valid=%b want 2/1/00000010/2/0",
               HTRANS, HWRITE, HADDR, HSIZE, rsp_valid);
    end
    tick();
    tests_run++;
    if (HTRANS !== IDLE || HWDATA !== 32'hDEADBEEF || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_data_phase: htrans=%0d hwdata=%h rsp_valid=%b want 0/deadbeef/0",
               HTRANS, HWDATA, rsp_valid);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL write_rsp: valid=%b error=%b rdata=%h want 1/0/00000000",
               rsp_valid, rsp_error, rsp_rdata);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_rsp_pulse: valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_read_wait;
    // Cycle index k is the cycle after edge k; command accepted at edge 0.
    // Data phase cycles 2..4 (HREADY low in 2 and 3), response in cycle 5.
    offer(1'b0, 32'h0000_0023, HALF_WORD, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      cmd_valid = 1'b0;
      HREADY = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      HRDATA = (k == 4) ? 32'hFEDC_BA98 : 32'h1111_1111;
      if (k == 1) begin
        tests_run++;
        if (HTRANS !== NONSEQ || HADDR !== 32'h0000_0022 || HWRITE !== 1'b0 || HSIZE !== HALF_WORD) begin
          tests_failed++;
          $display("[TB] FAIL read_addr_phase: htrans=%0d haddr=%h hwrite=%b hsize=%0d want 2/00000022/0/1",
                   HTRANS, HADDR, HWRITE, HSIZE);
        end
      end
      tests_run++;
      if (rsp_valid !== (k == 5)) begin
        tests_failed++;
        $display("[TB] FAIL read_rsp_timing cyc %0d: valid=%b want %b", k, rsp_valid, (k == 5));
      end
      if (k == 5) begin
        tests_run++;
        if (rsp_rdata !== 32'hFEDC_BA98 || rsp_error !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL read_rsp_data: rdata=%h error=%b want fedcba98/0", rsp_rdata, rsp_error);
        end
      end
    end
    HREADY = 1'b1;
    HRDATA = 32'h0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] wd [4];
    for (int i = 0; i < 4; i++) wd[i] = 32'hA000_0000 + 32'(i * 17);
    for (int c = 0; c <= 6; c++) begin
      if (c < 4) begin
        offer(1'b1, 32'(c * 4), WORD, wd[c]);
        tests_run++;
        if (cmd_ready !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL b2b_ready %0d: got %b want 1", c, cmd_ready);
        end
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      tests_run++;
      if (c < 4) begin
        if (HTRANS !== NONSEQ || HADDR !== 32'(c * 4)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_addr %0d: htrans=%0d haddr=%h want 2/%h", c, HTRANS, HADDR, 32'(c * 4));
        end
      end else if (HTRANS !== IDLE) begin
        tests_failed++;
        $display("[TB] FAIL b2b_idle %0d: htrans=%0d want 0", c, HTRANS);
      end
      if (c >= 1 && c <= 4) begin
        tests_run++;
        if (HWDATA !== wd[c-1]) begin
          tests_failed++;
          $display("[TB] FAIL b2b_hwdata %0d: got %h want %h", c, HWDATA, wd[c-1]);
        end
      end
      tests_run++;
      if (rsp_valid !== (c >= 2 && c <= 5)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_rsp %0d: valid=%b want %b", c, rsp_valid, (c >= 2 && c <= 5));
      end
    end
  endtask

  task automatic test_error;
    offer(1'b1, 32'h0000_0000, WORD, 32'hAAAA_5555);
    tick();
    offer(1'b0, 32'h0000_0004, WORD, 32'h0);
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_second_ready: got %b want 1", cmd_ready);
    end
    tick();
    // First ERROR cycle: write in data phase, read in address phase.
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    HRESP  = 1'b1;
    #1;
    tests_run++;
    if (HTRANS !== NONSEQ || HADDR !== 32'h4 || HWDATA !== 32'hAAAA_5555 || cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_cycle1: htrans=%0d haddr=%h hwdata=%h ready=%b want 2/00000004/aaaa5555/0",
               HTRANS, HADDR, HWDATA, cmd_ready);
    end
    tick();
    // Second ERROR cycle; a new command offered now must be refused.
    HREADY = 1'b1;
    offer(1'b1, 32'h0000_0080, WORD, 32'h5A5A_5A5A);
    #1;
    tests_run++;
    if (HTRANS !== IDLE || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_cycle2: htrans=%0d ready=%b rsp_valid=%b want 0/0/0", HTRANS, cmd_ready, rsp_valid);
    end
    tick();
    cmd_valid = 1'b0;
    HRESP  = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_rsp: valid=%b error=%b want 1/1", rsp_valid, rsp_error);
    end
    tests_run++;
    if (HTRANS !== NONSEQ || HADDR !== 32'h4 || HWRITE !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_reissue: htrans=%0d haddr=%h hwrite=%b want 2/00000004/0", HTRANS, HADDR, HWRITE);
    end
    tick();
    HRDATA = 32'h1234_5678;
    tests_run++;
    if (rsp_valid !== 1'b0 || HTRANS !== IDLE) begin
      tests_failed++;
      $display("[TB] FAIL err_read_data_phase: valid=%b htrans=%0d want 0/0", rsp_valid, HTRANS);
    end
    tick();
    HRDATA = 32'h0;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin
      tests_failed++;
      $display("[TB] FAIL err_read_rsp: valid=%b error=%b rdata=%h want 1/0/12345678",
               rsp_valid, rsp_error, rsp_rdata);
    end
    tick();
    tests_run++;
    if (rsp_valid !== 1'b0 || HTRANS !== IDLE) begin
      tests_failed++;
      $display("[TB] FAIL err_refused_cmd: valid=%b htrans=%0d want 0/0", rsp_valid, HTRANS);
    end
  endtask

  task automatic test_reset_mid;
    offer(1'b0, 32'h0000_0040, WORD, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0;
    tick();
    HRESETn = 1'b0;
    tick();
    tests_run++;
    if (HTRANS !== IDLE || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset: htrans=%0d rsp_valid=%b ready=%b want 0/0/0", HTRANS, rsp_valid, cmd_ready);
    end
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    HRDATA  = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (rsp_valid !== 1'b0 || HTRANS !== IDLE) begin
        tests_failed++;
        $display("[TB] FAIL midreset_no_rsp %0d: valid=%b htrans=%0d want 0/0", i, rsp_valid, HTRANS);
      end
    end
    HRDATA = 32'h0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_size  = BYTE;
    cmd_wdata = 32'h0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
